// File: rtl/oflow_core_write_sequencer.sv
// Write-side sequencer: walks conflict-resolved results row by row and group by group,
// offering each PE group to the MEM buffer over a valid/ready handshake.
module oflow_core_write_sequencer #(
  parameter int PE_NUM        = 24,
  parameter int GROUP         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SET_LEN       = 8,
  parameter int ROW_LEN       = 8,
  parameter int PE_LEN        = 5,
  parameter int GRP_LEN       = ($clog2((PE_NUM + GROUP - 1) / GROUP) < 1) ? 1
                                : $clog2((PE_NUM + GROUP - 1) / GROUP)
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start_write,
  input  logic               abort,
  input  logic [SET_LEN-1:0] num_of_sets,
  input  logic [PE_LEN-1:0]  num_of_bbox_in_last_set,
  input  logic               beat_ready,
  output logic               beat_valid,
  output logic [ROW_LEN-1:0] row_sel,
  output logic [GRP_LEN-1:0] grp_sel,
  output logic [GROUP-1:0]   lane_mask,
  output logic               last_beat,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OFFER  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int FULL_GRPS = (PE_NUM + GROUP - 1) / GROUP;
  localparam logic [PE_LEN-1:0] PE_NUM_L = PE_LEN'(PE_NUM);
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  // With no settle time every beat transition lands straight in OFFER.
  localparam state_t SETTLE_ENTRY = (SETTLE_CYCLES == 0) ? ST_OFFER : ST_SETTLE;

  // Returns {is_last_row, is_final_group_of_row} for the given position.
  function automatic logic [1:0] grp_flags(input logic [ROW_LEN-1:0] row,
                                           input logic [GRP_LEN-1:0] grp,
                                           input logic [SET_LEN-1:0] sets,
                                           input logic [PE_LEN-1:0]  cnt);
    int   n_grps;
    logic last_row;
    logic final_grp;
    last_row  = (int'(row) == int'(sets) - 32'sd1);
    n_grps    = last_row ? (int'(cnt) + GROUP - 32'sd1) / GROUP : FULL_GRPS;
    final_grp = (int'(grp) == n_grps - 32'sd1);
    return {last_row, final_grp};
  endfunction

  function automatic logic [GROUP-1:0] lane_bits(input logic last_row,
                                                 input logic final_grp,
                                                 input logic [PE_LEN-1:0] cnt);
    int               rem;
    logic [GROUP-1:0] mask;
    rem = last_row ? int'(cnt) % GROUP : PE_NUM % GROUP;
    if (final_grp && (rem != 32'sd0)) begin
      mask = GROUP'((32'd1 << rem) - 32'd1);
    end else begin
      mask = {GROUP{1'b1}};
    end
    return mask;
  endfunction

  state_t             state_q, state_d;
  logic [ROW_LEN-1:0] row_q, row_d;
  logic [GRP_LEN-1:0] grp_q, grp_d;
  logic [3:0]         settle_q, settle_d;
  logic [SET_LEN-1:0] sets_q, sets_d;
  logic [PE_LEN-1:0]  cnt_q, cnt_d;
  logic               beat_valid_q, beat_valid_d;
  logic [GROUP-1:0]   lane_mask_q, lane_mask_d;
  logic               last_beat_q, last_beat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         cur_flags_s;
  logic [1:0]         nxt_flags_s;
  logic               in_beat_s;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    grp_d       = grp_q;
    settle_d    = settle_q;
    sets_d      = sets_q;
    cnt_d       = cnt_q;
    cur_flags_s = grp_flags(row_q, grp_q, sets_q, cnt_q);

    case (state_q)
      ST_IDLE: begin
        row_d    = {ROW_LEN{1'b0}};
        grp_d    = {GRP_LEN{1'b0}};
        settle_d = 4'd0;
        if (start_write) begin
          sets_d  = num_of_sets;
          cnt_d   = ((num_of_bbox_in_last_set == {PE_LEN{1'b0}}) ||
                     (num_of_bbox_in_last_set > PE_NUM_L)) ? PE_NUM_L : num_of_bbox_in_last_set;
          state_d = (num_of_sets == {SET_LEN{1'b0}}) ? ST_DONE : SETTLE_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_OFFER;
          settle_d = 4'd0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_OFFER: begin
        settle_d = 4'd0;
        if (beat_ready) begin
          if (cur_flags_s[1] && cur_flags_s[0]) begin
            state_d = ST_DONE;
          end else if (cur_flags_s[0]) begin
            row_d   = row_q + ROW_LEN'(1);
            grp_d   = {GRP_LEN{1'b0}};
            state_d = SETTLE_ENTRY;
          end else begin
            grp_d   = grp_q + GRP_LEN'(1);
            state_d = SETTLE_ENTRY;
          end
        end else begin
          state_d = ST_OFFER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        row_d   = {ROW_LEN{1'b0}};
        grp_d   = {GRP_LEN{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      row_d    = {ROW_LEN{1'b0}};
      grp_d    = {GRP_LEN{1'b0}};
      settle_d = 4'd0;
    end else begin
      state_d  = state_d;
    end

    // Outputs are registered, so derive them from the position being entered.
    nxt_flags_s  = grp_flags(row_d, grp_d, sets_d, cnt_d);
    in_beat_s    = (state_d == ST_SETTLE) || (state_d == ST_OFFER);
    beat_valid_d = (state_d == ST_OFFER);
    lane_mask_d  = in_beat_s ? lane_bits(nxt_flags_s[1], nxt_flags_s[0], cnt_d)
                             : {GROUP{1'b0}};
    last_beat_d  = in_beat_s && nxt_flags_s[1] && nxt_flags_s[0];
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= ST_IDLE;
      row_q        <= {ROW_LEN{1'b0}};
      grp_q        <= {GRP_LEN{1'b0}};
      settle_q     <= 4'd0;
      sets_q       <= {SET_LEN{1'b0}};
      cnt_q        <= {PE_LEN{1'b0}};
      beat_valid_q <= 1'b0;
      lane_mask_q  <= {GROUP{1'b0}};
      last_beat_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      grp_q        <= grp_d;
      settle_q     <= settle_d;
      sets_q       <= sets_d;
      cnt_q        <= cnt_d;
      beat_valid_q <= beat_valid_d;
      lane_mask_q  <= lane_mask_d;
      last_beat_q  <= last_beat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign beat_valid = beat_valid_q;
  assign row_sel    = row_q;
  assign grp_sel    = grp_q;
  assign lane_mask  = lane_mask_q;
  assign last_beat  = last_beat_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_oflow_core_write_sequencer.sv
// Directed bench for oflow_core_write_sequencer at default parameters
// (PE_NUM=24, GROUP=4, SETTLE_CYCLES=2: 6 groups per full row, 3-cycle beat period).
module tb_oflow_core_write_sequencer;

  logic       clk = 1'b0;
  logic       reset_N = 1'b0;
  logic       start_write = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_of_sets = 8'd0;
  logic [4:0] num_of_bbox_in_last_set = 5'd0;
  logic       beat_ready = 1'b1;
  logic       beat_valid;
  logic [7:0] row_sel;
  logic [2:0] grp_sel;
  logic [3:0] lane_mask;
  logic       last_beat;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  oflow_core_write_sequencer dut (
    .clk(clk), .reset_N(reset_N), .start_write(start_write), .abort(abort),
    .num_of_sets(num_of_sets), .num_of_bbox_in_last_set(num_of_bbox_in_last_set),
    .beat_ready(beat_ready), .beat_valid(beat_valid), .row_sel(row_sel),
    .grp_sel(grp_sel), .lane_mask(lane_mask), .last_beat(last_beat),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         sets;
    int         cnt;
    int         beats;
    logic [3:0] last_mask;
  } vec_t;

  // Runs one frame with beat_ready high; beat k is expected at row k/6, group k%6,
  // in cycle 3+3k after the start edge. Optionally pokes start_write mid-frame.
  task automatic run_frame(input int sets, input int cnt, input int exp_beats,
                           input logic [3:0] exp_last_mask, input bit poke);
    int beats = 0;
    int last_acc = -1;
    int done_cyc = -1;
    @(negedge clk);
    start_write = 1'b1;
    num_of_sets = 8'(sets);
    num_of_bbox_in_last_set = 5'(cnt);
    @(negedge clk);
    start_write = 1'b0;
    chk("busy_cycle1", int'(busy), 1);
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (poke && c == 4) begin
        start_write = 1'b1;
        num_of_sets = 8'd5;
      end else if (poke && c == 5) begin
        start_write = 1'b0;
      end
      if (beat_valid && beat_ready) begin
        chk("beat_cycle", c, 3 + 3 * beats);
        chk("beat_row", int'(row_sel), beats / 6);
        chk("beat_grp", int'(grp_sel), beats % 6);
        chk("beat_mask", int'(lane_mask),
            (beats == exp_beats - 1) ? int'(exp_last_mask) : 15);
        chk("beat_last", int'(last_beat), (beats == exp_beats - 1) ? 1 : 0);
        beats++;
        last_acc = c;
      end
      if (done) begin
        done_cyc = c;
        chk("done_mask_zero", int'(lane_mask), 0);
        chk("done_valid_zero", int'(beat_valid), 0);
      end
    end
    chk("done_seen", int'(done_cyc > 0), 1);
    chk("beat_count", beats, exp_beats);
    chk("done_cycle", done_cyc, (exp_beats > 0) ? last_acc + 1 : 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int hit;
    vecs[0] = '{2, 24, 12, 4'hF};
    vecs[1] = '{1, 6, 2, 4'h3};
    vecs[2] = '{3, 3, 13, 4'h7};
    vecs[3] = '{1, 0, 6, 4'hF};
    vecs[4] = '{1, 31, 6, 4'hF};
    vecs[5] = '{2, 1, 7, 4'h1};
    vecs[6] = '{1, 5, 2, 4'h1};

    repeat (3) @(negedge clk);
    chk("rst_valid", int'(beat_valid), 0);
    chk("rst_row", int'(row_sel), 0);
    chk("rst_grp", int'(grp_sel), 0);
    chk("rst_mask", int'(lane_mask), 0);
    chk("rst_last", int'(last_beat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_N = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].sets, vecs[i].cnt, vecs[i].beats, vecs[i].last_mask, 1'b0);
    end

    // Zero sets, then a start pulsed mid-frame that must be ignored.
    run_frame(0, 5, 0, 4'hF, 1'b0);
    run_frame(1, 8, 2, 4'hF, 1'b1);

    // Backpressure: hold the first beat for 5 cycles, accept on the 6th.
    beat_ready = 1'b0;
    @(negedge clk);
    start_write = 1'b1;
    num_of_sets = 8'd1;
    num_of_bbox_in_last_set = 5'd8;
    @(negedge clk);
    start_write = 1'b0;
    hit = 0;
    for (int c = 0; c < 50 && hit == 0; c++) begin
      if (beat_valid) hit = 1;
      else @(negedge clk);
    end
    chk("bp_valid_seen", hit, 1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", int'(beat_valid), 1);
      chk("bp_hold_grp", int'(grp_sel), 0);
      chk("bp_hold_mask", int'(lane_mask), 15);
      chk("bp_hold_last", int'(last_beat), 0);
      @(negedge clk);
    end
    chk("bp_still_valid", int'(beat_valid), 1);
    beat_ready = 1'b1;
    @(negedge clk);
    chk("bp_adv_grp", int'(grp_sel), 1);
    chk("bp_adv_valid", int'(beat_valid), 0);
    chk("bp_adv_last", int'(last_beat), 1);
    hit = 0;
    for (int c = 0; c < 50 && hit == 0; c++) begin
      @(negedge clk);
      if (done) hit = 1;
    end
    chk("bp_done", hit, 1);

    // Abort at row 1 group 2, coinciding with an accept.
    @(negedge clk);
    start_write = 1'b1;
    num_of_sets = 8'd2;
    num_of_bbox_in_last_set = 5'd24;
    @(negedge clk);
    start_write = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && hit == 0; c++) begin
      if (beat_valid && row_sel == 8'd1 && grp_sel == 3'd2) hit = 1;
      else @(negedge clk);
    end
    chk("abort_target_seen", hit, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(beat_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_row", int'(row_sel), 0);
    chk("abort_grp", int'(grp_sel), 0);
    chk("abort_done", int'(done), 0);
    hit = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) hit = 1;
    end
    chk("abort_quiet", hit, 0);
    run_frame(1, 4, 1, 4'hF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
